// File: rtl/clkgen_multi_pkg.sv
// Shared defaults and helpers for the multi-channel clock-enable generator.
// Optional square-wave outputs are controlled by the CLKGEN_CLKOUT_EN macro.
package clkgen_pkg;

  localparam int NUM_CH_DEF    = 3;
  localparam int CNT_W_DEF     = 24;
  localparam int DIV_RESET_DEF = 4;
  localparam int DIV_HALT      = 0;

  // Counter value at which clk_out goes high; CNT_W up to 64 bits is supported.
  function automatic logic [63:0] half_thresh(input logic [63:0] div);
    return div >> 1;
  endfunction

endpackage

// File: rtl/clkgen_multi_if.sv
// Control and output bundle for clkgen_multi; master drives the controls,
// slave (the generator) drives ticks, acks and square waves.
interface clkgen_multi_if
  import clkgen_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic                      en;
  logic                      sync;
  logic [NUM_CH*CNT_W-1:0]   div_in;
  logic [NUM_CH-1:0]         div_load;
  logic [NUM_CH-1:0]         div_ack;
  logic [NUM_CH-1:0]         tick;
  logic [NUM_CH-1:0]         clk_out;

  modport master (
    output en, sync, div_in, div_load,
    input  div_ack, tick, clk_out
  );

  modport slave (
    input  en, sync, div_in, div_load,
    output div_ack, tick, clk_out
  );

endinterface

// File: rtl/clkgen_multi_chan.sv
// One divider channel: counter, current/pending divisor and glitch-free apply.
// clk_out logic exists only when CLKGEN_CLKOUT_EN is defined.
module clkgen_chan
  import clkgen_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DIV_RESET = DIV_RESET_DEF
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             sync,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  output logic             tick,
  output logic             clk_out
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] div_pend_q, div_pend_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;

  logic             pend_eff;
  logic [CNT_W-1:0] pend_val;
  logic             halted;
  logic             wrap;
  logic             apply;

  always_comb begin
    // A load in the apply cycle is folded straight into that apply.
    pend_eff   = pend_q | div_load;
    pend_val   = div_load ? div_in : div_pend_q;
    halted     = (div_cur_q == CNT_W'(DIV_HALT));
    wrap       = !halted && en && (cnt_q >= div_cur_q - CNT_W'(1));
    apply      = pend_eff && (sync || halted || wrap);

    cnt_d      = cnt_q;
    if (sync || halted || wrap) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    div_cur_d  = apply ? pend_val : div_cur_q;
    div_pend_d = div_load ? div_in : div_pend_q;
    pend_d     = pend_eff && !apply;
    ack_d      = apply;
    tick_d     = en && (div_cur_d != CNT_W'(DIV_HALT)) &&
                 (cnt_d == div_cur_d - CNT_W'(1));
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q      <= '0;
      div_cur_q  <= CNT_W'(DIV_RESET);
      div_pend_q <= '0;
      pend_q     <= 1'b0;
      tick_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
      ack_q      <= ack_d;
    end
  end

  assign tick    = tick_q;
  assign div_ack = ack_q;

`ifdef CLKGEN_CLKOUT_EN
  logic clk_out_q, clk_out_d;

  // Square wave holds while disabled, but follows any restart or apply.
  always_comb begin
    clk_out_d = clk_out_q;
    if (en || sync || apply) begin
      clk_out_d = (div_cur_d != CNT_W'(DIV_HALT)) &&
                  (cnt_d >= CNT_W'(half_thresh(64'(div_cur_d))));
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      clk_out_q <= 1'b0;
    end else begin
      clk_out_q <= clk_out_d;
    end
  end

  assign clk_out = clk_out_q;
`else
  assign clk_out = 1'b0;
`endif

endmodule

// File: rtl/clkgen_multi.sv
// Multi-channel programmable clock-enable generator; slices the bus per channel.
// Build with CLKGEN_CLKOUT_EN defined to get the clk_out square waves.
module clkgen_multi
  import clkgen_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DIV_RESET = DIV_RESET_DEF
) (
  input  logic           clk,
  input  logic           clr_n,
  clkgen_multi_if.slave  bus
);

  logic [NUM_CH-1:0] ack_w;
  logic [NUM_CH-1:0] tick_w;
  logic [NUM_CH-1:0] clk_out_w;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      clkgen_chan #(
        .CNT_W     (CNT_W),
        .DIV_RESET (DIV_RESET)
      ) u_chan (
        .clk      (clk),
        .clr_n    (clr_n),
        .en       (bus.en),
        .sync     (bus.sync),
        .div_in   (bus.div_in[gi*CNT_W +: CNT_W]),
        .div_load (bus.div_load[gi]),
        .div_ack  (ack_w[gi]),
        .tick     (tick_w[gi]),
        .clk_out  (clk_out_w[gi])
      );
    end
  endgenerate

  assign bus.div_ack = ack_w;
  assign bus.tick    = tick_w;
  assign bus.clk_out = clk_out_w;

endmodule

// File: tb/tb_clkgen_multi.sv
// Scoreboard bench for clkgen_multi: directed scenarios then random traffic,
// checked cycle by cycle against a behavioural divider model.
module tb_clkgen_multi;
  import clkgen_pkg::*;

  localparam int NUM_CH    = 3;
  localparam int CNT_W     = 24;
  localparam int DIV_RESET = 4;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  clkgen_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus();

  clkgen_multi #(
    .NUM_CH    (NUM_CH),
    .CNT_W     (CNT_W),
    .DIV_RESET (DIV_RESET)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clko;
    logic [NUM_CH-1:0] ack;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: phase, period, pending divisor per channel.
  int m_cnt  [NUM_CH];
  int m_div  [NUM_CH];
  int m_pdiv [NUM_CH];
  bit m_pend [NUM_CH];
  bit m_clko [NUM_CH];

  // Stimulus for the next clock edge.
  bit clr_v = 1'b0;
  bit en_v  = 1'b0;
  bit sync_v = 1'b0;
  bit ld_v  [NUM_CH];
  int din_v [NUM_CH];

  task automatic check(input string name, input logic [NUM_CH-1:0] act,
                       input logic [NUM_CH-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(output exp_t e);
    bit has_new;
    int new_div;
    bit ack;
    e = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!clr_v) begin
        m_cnt[i]  = 0;
        m_div[i]  = DIV_RESET;
        m_pdiv[i] = 0;
        m_pend[i] = 1'b0;
        m_clko[i] = 1'b0;
      end else begin
        has_new = ld_v[i] || m_pend[i];
        new_div = ld_v[i] ? din_v[i] : m_pdiv[i];
        ack     = 1'b0;
        // Restart points: sync, a halted channel, or the end of a running period.
        if (sync_v || m_div[i] == 0 || (en_v && m_cnt[i] == m_div[i] - 1)) begin
          m_cnt[i] = 0;
          if (has_new) begin
            m_div[i] = new_div;
            ack      = 1'b1;
            has_new  = 1'b0;
          end
        end else if (en_v) begin
          m_cnt[i] = m_cnt[i] + 1;
        end
        m_pend[i] = has_new;
        if (ld_v[i]) m_pdiv[i] = din_v[i];
        e.ack[i]  = ack;
        e.tick[i] = en_v && m_div[i] != 0 && m_cnt[i] == m_div[i] - 1;
        if (en_v || sync_v || ack)
          m_clko[i] = (m_div[i] != 0) && (m_cnt[i] >= m_div[i] / 2);
`ifdef CLKGEN_CLKOUT_EN
        e.clko[i] = m_clko[i];
`endif
      end
    end
  endtask

  task automatic drive_cycle();
    exp_t e;
    @(negedge clk);
    clr_n    = clr_v;
    bus.en   = en_v;
    bus.sync = sync_v;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.div_load[i] = ld_v[i];
      bus.div_in[i*CNT_W +: CNT_W] = CNT_W'(din_v[i]);
      if (ld_v[i]) $display("load ch%0d div=%0d sync=%0b at %0t", i, din_v[i], sync_v, $time);
    end
    if (sync_v) $display("sync at %0t", $time);
    model_step(e);
    exp_q.push_back(e);
    last_exp = e;
    sync_v = 1'b0;
    for (int i = 0; i < NUM_CH; i++) ld_v[i] = 1'b0;
  endtask

  task automatic load(input int ch, input int div);
    ld_v[ch]  = 1'b1;
    din_v[ch] = div;
  endtask

  task automatic wait_cnt(input int ch, input int val);
    for (int k = 0; k < 64 && m_cnt[ch] != val; k++) drive_cycle();
  endtask

  // Monitor: one expected entry per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("tick",    bus.tick,    e.tick);
        check("clk_out", bus.clk_out, e.clko);
        check("div_ack", bus.div_ack, e.ack);
      end
    end
  end

  initial begin
    bus.en = 1'b0;
    bus.sync = 1'b0;
    bus.div_in = '0;
    bus.div_load = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ld_v[i] = 1'b0;
      din_v[i] = 0;
    end

    repeat (3) drive_cycle();               // held in reset
    clr_v = 1'b1;
    en_v  = 1'b1;
    repeat (12) drive_cycle();              // default divide-by-4

    wait_cnt(0, 1);                         // reload ch0 mid-period
    load(0, 10);
    drive_cycle();
    repeat (25) drive_cycle();

    wait_cnt(1, 0);                         // overwrite before wrap, odd divisor
    load(1, 7);
    drive_cycle();
    load(1, 3);
    drive_cycle();
    repeat (12) drive_cycle();

    load(2, 0);                             // halt then restart ch2
    drive_cycle();
    repeat (8) drive_cycle();
    load(2, 5);
    drive_cycle();
    repeat (12) drive_cycle();

    load(0, 4); load(1, 6); load(2, 9);     // sync with a same-cycle load
    drive_cycle();
    repeat (15) drive_cycle();
    sync_v = 1'b1;
    load(0, 2);
    drive_cycle();
    repeat (12) drive_cycle();

    repeat (2) drive_cycle();               // enable pause
    en_v = 1'b0;
    repeat (5) drive_cycle();
    en_v = 1'b1;
    repeat (10) drive_cycle();

    load(1, 8);                             // async reset mid-load, while ticking
    drive_cycle();
    for (int k = 0; k < 20 && last_exp.tick == '0; k++) drive_cycle();
    @(posedge clk);
    #3;
    clr_n = 1'b0;
    clr_v = 1'b0;
    #1;
    check("async_rst_tick",    bus.tick,    '0);
    check("async_rst_clk_out", bus.clk_out, '0);
    check("async_rst_ack",     bus.div_ack, '0);
    repeat (2) drive_cycle();
    clr_v = 1'b1;
    repeat (12) drive_cycle();

    for (int n = 0; n < 400; n++) begin     // random traffic
      en_v   = ($urandom % 10) != 0;
      sync_v = ($urandom % 25) == 0;
      for (int i = 0; i < NUM_CH; i++)
        if (($urandom % 12) == 0) load(i, int'($urandom_range(0, 12)));
      drive_cycle();
    end

    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clkgen_multi.md
# clkgen_multi

Parametrised multi-channel clock-enable generator that replaces single fixed divide-by-4 dividers. Each channel has a run-time programmable divisor and produces a one-cycle `tick` enable and a square-wave `clk_out`. The block sits next to the board clock input and feeds the VGA pixel enable, game-logic timers and the animation/scroll rate. Divisor changes are glitch-free, and a global `sync` restarts all channels phase-aligned.

## Interface
- `NUM_CH`, default 3: number of independent channels.
- `CNT_W`, default 24: counter and divisor width in bits.
- `DIV_RESET`, default 4: divisor loaded into every channel at reset; must be ≥ 2.

- `clk`, in, 1: single system clock. All logic runs on its rising edge.
- `clr_n`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: global run enable.
- `sync`, in, 1: one-cycle pulse that restarts all channels at phase 0.
- `div_in`, in, NUM_CH*CNT_W: new divisor per channel. Channel i uses bits `[i*CNT_W +: CNT_W]`.
- `div_load`, in, NUM_CH: per-channel strobe that captures `div_in`.
- `div_ack`, out, NUM_CH: one-cycle pulse in the first cycle the new divisor is in effect.
- `tick`, out, NUM_CH: one-cycle enable pulse, once per divisor period.
- `clk_out`, out, NUM_CH: divided square wave; not a clock net, used for logic and LEDs only.

## Operation
Each channel holds `cnt` (CNT_W bits), `div_cur`, `div_pend` and a `pend` flag.
- **Counting:** when `en`=1 and `div_cur`≥1, `cnt` steps 0, 1, …, `div_cur`−1, then wraps to 0. The period is `div_cur` cycles.
- **Registered outputs:** `tick` and `clk_out` are flops, aligned with `cnt`.
  - `tick` = (`cnt` == `div_cur`−1).
  - `clk_out` = (`cnt` ≥ `div_cur`>>1).
  - Odd divisors: the low phase is shorter by one cycle.
- **`div_cur` = 1:** `tick` is constantly 1 and `clk_out` is constantly 1.
- **`div_cur` = 0:** the channel is halted. `cnt` = 0, `tick` = 0, `clk_out` = 0.
- **Run enable:** when `en`=0, `cnt` freezes, `tick` is forced to 0 and `clk_out` holds its value. Pending loads wait.
- **Load:** `div_load[i]` sets `div_pend` ← `div_in` slice and sets `pend`.
  - A second load before the change is applied overwrites `div_pend` (last wins). Only one `div_ack` is issued.
- **Apply:** the pending divisor is applied at the wrap, i.e. the cycle `cnt` goes from `div_cur`−1 to 0. Applying sets `div_cur` ← `div_pend`, clears `pend` and pulses `div_ack`.
  - A halted channel (`div_cur`=0) applies on the next cycle, regardless of `en`.
- **Sync:** `sync`=1 sets every `cnt` to 0 on the next edge and applies any pending divisor immediately (with `div_ack`).
  - A `div_load` in the same cycle as `sync` is included in that apply.
  - `sync` has priority over normal counting and wrap.
- **Reset:** `clr_n` low asynchronously sets:
  - `cnt` = 0, `div_cur` = `DIV_RESET`, `pend` = 0;
  - all outputs to 0.
  - A reset mid-load discards the pending divisor.

## Timing
- First `tick` after reset release with `en`=1: asserted in cycle `DIV_RESET` (cycles numbered from 1 at the first enabled edge).
- `div_load` to `div_ack` latency: 1 to `div_cur` cycles for a running channel; 1 cycle after `sync`.
- The new period starts on the cycle `div_ack` is high, with `cnt` = 0.
- `sync` to phase alignment: 1 cycle. After it, all channels have `cnt` = 0 in the same cycle.
- No combinational path exists from any input to any output.

## Configuration
- `CLKGEN_CLKOUT_EN`
  - **Defined:** `clk_out` comparators and flops are built as described above.
  - **Undefined:** `clk_out` is tied to 0 and no comparator logic is generated.
  - `tick` and `div_ack` behaviour is identical either way.

## Structure
- Package `clkgen_pkg`:
  - default widths;
  - `DIV_HALT` = 0 constant;
  - a function returning the half-period threshold (`div`>>1).
- Sub-module `clkgen_chan`: one channel (counter, divisor registers, apply logic). Instantiated NUM_CH times in a generate loop; the top level only slices buses and fans out `en`, `sync` and `clr_n`.

## Test plan
- **Reset default:** release reset, `en`=1, default params.
  - `tick` on every channel pulses every 4 cycles.
  - `clk_out` pattern is 0,0,1,1.
  - `div_ack` stays 0.
- **Glitch-free reload:** on ch0 (`div_cur`=4), `div_load` with `div_in`=10 when `cnt`=1.
  - `div_ack` fires 3 cycles later.
  - Then `tick` has a 10-cycle period; `clk_out` is low 5 cycles and high 5 cycles.
  - No short pulse appears.
- **Overwrite and odd divisor:** on ch1, load 7, then load 3 before the wrap.
  - Exactly one `div_ack`.
  - Period becomes 3; `clk_out` is 0,1,1.
- **Halt and restart:** load 0 on ch2.
  - After the wrap the channel halts: `tick` = 0 and `clk_out` = 0.
  - Load 5: `div_ack` on the next cycle, then 5-cycle ticks.
- **Sync with loads:** channels at divisors 4, 6, 9 mid-count; pulse `sync` together with `div_load[0]` = 2.
  - Next cycle: all `cnt` = 0 and `div_ack[0]` = 1.
  - Ticks then occur at cycles 2, 6, 9 after the sync.
- **Enable and async reset:** `en`=0 for 5 cycles mid-period.
  - Counters freeze and no `tick` is emitted; the period resumes where it stopped.
  - Assert `clr_n`=0 between clock edges: outputs clear immediately, and divisors return to 4.
